sync_bank: RTL and testbench

Multi-channel, single-clock input conditioner for asynchronous signals such as buttons, switches, and external strobes. Each channel passes through a parametrised-depth synchronizer, then an optional stability (debounce) filter. Each channel produces a clean level plus one-cycle rise and fall pulses. It generalises the fixed two-flop transfer pipe used elsewhere in the design: width, depth, reset value and filtering are all configurable, and edge outputs are new.

---
 rtl/sync_pkg.sv | 17 +
 rtl/sync_bank_chan.sv | 73 +++++++
 rtl/sync_bank.sv | 41 ++++
 tb/tb_sync_bank.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared constants and helpers for the synchronizer/debounce bank.
package sync_pkg;

    localparam int unsigned SYNC_MIN_STAGES = 2;

    // Required run of stable samples; 0 and 1 both mean "follow next sample".
    function automatic int unsigned dbnc_len(input int n);
        int unsigned len;
        len = (n > 1) ? unsigned'(n) : 32'd1;
        return len;
    endfunction

    function automatic int unsigned dbnc_cnt_w(input int n);
        return unsigned'($clog2(dbnc_len(n) + 32'd1));
    endfunction

endpackage

// File: rtl/sync_bank_chan.sv
// One conditioned channel: synchronizer chain, stability counter, level and edge registers.
module sync_bank_chan
    import sync_pkg::*;
#(
    parameter int unsigned STAGES          = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter logic        RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned RUN_LEN = dbnc_len(int'(DEBOUNCE_CYCLES));
    localparam int unsigned CNT_W   = dbnc_cnt_w(int'(DEBOUNCE_CYCLES));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_LEN - 32'd1);

    (* async_reg = "true" *) logic [STAGES-1:0] sync;

    logic             sample;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             rise_nxt;
    logic             fall_nxt;

    assign sample = sync[STAGES-1];

    // Chain resets to the same value as level_o so a quiet input gives no pulse on release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= {STAGES{RST_VAL}};
        end else begin
            sync <= {sync[STAGES-2:0], async_i};
        end
    end

    // Any sample matching the current level discards the partial run.
    always_comb begin
        cnt_nxt   = cnt;
        level_nxt = level_o;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (sample == level_o) begin
            cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            level_nxt = sample;
            rise_nxt  = sample;
            fall_nxt  = !sample;
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            level_o <= RST_VAL;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            level_o <= level_nxt;
            rise_o  <= rise_nxt;
            fall_o  <= fall_nxt;
        end
    end

endmodule

// File: rtl/sync_bank.sv
// Bank of independent single-bit input conditioners; not for multi-bit buses.
module sync_bank
    import sync_pkg::*;
#(
    parameter int unsigned          CHANNELS        = 4,
    parameter int unsigned          STAGES          = 2,
    parameter int unsigned          DEBOUNCE_CYCLES = 0,
    parameter logic [CHANNELS-1:0]  RESET_VALUE     = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] async_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o
);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("sync_bank: CHANNELS must be at least 1");
    end

    if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
        $error("sync_bank: STAGES must be at least SYNC_MIN_STAGES");
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        sync_bank_chan #(
            .STAGES          (STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RST_VAL         (RESET_VALUE[c])
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .async_i (async_i[c]),
            .level_o (level_o[c]),
            .rise_o  (rise_o[c]),
            .fall_o  (fall_o[c])
        );
    end

endmodule

// File: tb/tb_sync_bank.sv
// Bench for sync_bank: four parameterisations checked against a sample-window reference model.
module tb_sync_bank;

    localparam int NI = 4;
    localparam int HL = 16;

    typedef struct {
        logic       rst_n;
        logic [3:0] in;
        logic [3:0] lvl;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    logic       clk;
    logic [3:0] ain  [NI];
    logic       rstn [NI];
    logic [3:0] lvl  [NI];
    logic [3:0] ris  [NI];
    logic [3:0] fal  [NI];

    int vectors = 0;
    int misc    = 0;

    // Per-instance configuration: synchronizer depth, effective run length, reset value.
    int         s_of  [NI] = '{2, 3, 2, 2};
    int         d_of  [NI] = '{1, 4, 1, 8};
    logic [3:0] rv_of [NI] = '{4'b0000, 4'b0000, 4'b1010, 4'b0000};

    logic [3:0] hist    [NI][HL];
    logic [3:0] m_lvl   [NI];
    logic [3:0] m_rise  [NI];
    logic [3:0] m_fall  [NI];
    int         m_trans [NI] = '{0, 0, 0, 0};
    int         d_pulses[NI] = '{0, 0, 0, 0};

    vec_t tbl [15];

    sync_bank u_dut0 (
        .clk(clk), .rst_n(rstn[0]), .async_i(ain[0]),
        .level_o(lvl[0]), .rise_o(ris[0]), .fall_o(fal[0])
    );

    sync_bank #(.STAGES(3), .DEBOUNCE_CYCLES(4)) u_dut1 (
        .clk(clk), .rst_n(rstn[1]), .async_i(ain[1]),
        .level_o(lvl[1]), .rise_o(ris[1]), .fall_o(fal[1])
    );

    sync_bank #(.RESET_VALUE(4'b1010)) u_dut2 (
        .clk(clk), .rst_n(rstn[2]), .async_i(ain[2]),
        .level_o(lvl[2]), .rise_o(ris[2]), .fall_o(fal[2])
    );

    sync_bank #(.DEBOUNCE_CYCLES(8)) u_dut3 (
        .clk(clk), .rst_n(rstn[3]), .async_i(ain[3]),
        .level_o(lvl[3]), .rise_o(ris[3]), .fall_o(fal[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Level flips once the last run-length samples all disagree with it; hist[k] = input k+1 edges ago.
    task automatic model_edge(input int i);
        logic [3:0] nl;
        bit         all_diff;
        if (!rstn[i]) begin
            for (int k = 0; k < HL; k++) hist[i][k] = rv_of[i];
            m_lvl[i]  = rv_of[i];
            m_rise[i] = 4'b0;
            m_fall[i] = 4'b0;
        end else begin
            nl = m_lvl[i];
            for (int c = 0; c < 4; c++) begin
                all_diff = 1'b1;
                for (int k = s_of[i] - 1; k <= s_of[i] + d_of[i] - 2; k++)
                    if (hist[i][k][c] == m_lvl[i][c]) all_diff = 1'b0;
                if (all_diff) nl[c] = ~m_lvl[i][c];
            end
            m_rise[i]  = nl & ~m_lvl[i];
            m_fall[i]  = ~nl & m_lvl[i];
            m_trans[i] += $countones(nl ^ m_lvl[i]);
            m_lvl[i]   = nl;
            for (int k = HL - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0] = ain[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < NI; i++) model_edge(i);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("model_inst%0d", i),
                  {20'b0, lvl[i], ris[i], fal[i]}, {20'b0, m_lvl[i], m_rise[i], m_fall[i]});
            check($sformatf("rise_and_fall_inst%0d", i), 32'(ris[i] & fal[i]), 32'd0);
            d_pulses[i] += $countones(ris[i] | fal[i]);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[2]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[3]  = '{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        tbl[4]  = '{1'b1, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        tbl[5]  = '{1'b1, 4'b0101, 4'b0001, 4'b0000, 4'b0000};
        tbl[6]  = '{1'b1, 4'b0101, 4'b0001, 4'b0000, 4'b0000};
        tbl[7]  = '{1'b1, 4'b1010, 4'b0101, 4'b0100, 4'b0000};
        tbl[8]  = '{1'b1, 4'b1010, 4'b0101, 4'b0000, 4'b0000};
        tbl[9]  = '{1'b1, 4'b1010, 4'b1010, 4'b1010, 4'b0101};
        tbl[10] = '{1'b1, 4'b1010, 4'b1010, 4'b0000, 4'b0000};
        tbl[11] = '{1'b1, 4'b0000, 4'b1010, 4'b0000, 4'b0000};
        tbl[12] = '{1'b1, 4'b0000, 4'b1010, 4'b0000, 4'b0000};
        tbl[13] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1010};
        tbl[14] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        for (int i = 0; i < NI; i++) begin
            rstn[i] = 1'b0;
            ain[i]  = 4'b0000;
        end
        ain[2] = 4'b1010;

        // Directed table on the default instance; the 1010-reset instance must stay quiet throughout.
        for (int t = 0; t < 15; t++) begin
            for (int i = 0; i < NI; i++) rstn[i] = tbl[t].rst_n;
            ain[0] = tbl[t].in;
            step();
            check($sformatf("tbl%0d_level", t), 32'(lvl[0]), 32'(tbl[t].lvl));
            check($sformatf("tbl%0d_rise", t),  32'(ris[0]), 32'(tbl[t].rise));
            check($sformatf("tbl%0d_fall", t),  32'(fal[0]), 32'(tbl[t].fall));
            check("rv_level",  32'(lvl[2]), 32'h0000_000a);
            check("rv_pulses", 32'(ris[2] | fal[2]), 32'd0);
        end
        for (int t = 0; t < 6; t++) begin
            step();
            check("rv_level",  32'(lvl[2]), 32'h0000_000a);
            check("rv_pulses", 32'(ris[2] | fal[2]), 32'd0);
        end

        // Run of 3 samples is one short of the 4-sample filter.
        ain[1] = 4'b0010;
        for (int n = 0; n < 11; n++) begin
            if (n == 3) ain[1] = 4'b0000;
            step();
            check("short_run_level", 32'(lvl[1][1]), 32'd0);
            check("short_run_rise",  32'(ris[1][1]), 32'd0);
        end
        ain[1] = 4'b0010;
        step();
        for (int n = 1; n <= 7; n++) begin
            step();
            check($sformatf("long_run_level_e%0d", n), 32'(lvl[1][1]), 32'(n >= 6));
            check($sformatf("long_run_rise_e%0d", n),  32'(ris[1][1]), 32'(n == 6));
        end

        // Reset after 5 counted samples throws the pending change away.
        ain[3] = 4'b0001;
        step();
        for (int n = 1; n <= 6; n++) begin
            step();
            check("pre_reset_level", 32'(lvl[3][0]), 32'd0);
        end
        rstn[3] = 1'b0;
        step();
        check("mid_reset_level",  32'(lvl[3]), 32'd0);
        check("mid_reset_pulses", 32'(ris[3] | fal[3]), 32'd0);
        rstn[3] = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            check($sformatf("post_reset_level_e%0d", n), 32'(lvl[3][0]), 32'(n == 10));
            check($sformatf("post_reset_rise_e%0d", n),  32'(ris[3][0]), 32'(n == 10));
            check($sformatf("post_reset_fall_e%0d", n),  32'(fal[3][0]), 32'd0);
        end

        // Random toggling with rare resets; toggle rate scaled to each instance's filter length.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < NI; i++) begin
                rstn[i] = ($urandom_range(0, 999) != 0);
                for (int c = 0; c < 4; c++)
                    if ($urandom_range(0, d_of[i]) == 0) ain[i][c] = ~ain[i][c];
            end
            step();
        end

        for (int i = 0; i < NI; i++)
            check($sformatf("pulse_count_inst%0d", i), 32'(d_pulses[i]), 32'(m_trans[i]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
